rx_buffer: RTL

RX_BUFFER -- requirements
Module: rx_buffer

---
 rtl/bitonic_pkg.sv | 16 +
 rtl/array_fifo.sv | 76 +++++++
 rtl/rx_buffer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bitonic_pkg.sv
// Shared definitions for the array buffers and the sorter: default geometry,
// the array type carried between blocks, and a small width helper.
package bitonic_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_NUM_SEQ = 10;

    typedef logic [DEF_DEPTH-1:0][DEF_WIDTH-1:0] array_t;

    // Counter/pointer width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/array_fifo.sv
// Circular FIFO of whole arrays. The head is read combinationally so a pushed
// array is visible the cycle after it is written. A push into a full FIFO is
// accepted only when a pop frees a slot on the same cycle; otherwise it is
// dropped and reported through the one-cycle drop strobe.
module array_fifo
    import bitonic_pkg::*;
#(
    parameter int  NUM_SEQ = DEF_NUM_SEQ,
    parameter type T       = array_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic not_empty,
    output logic full,
    output logic drop
);

    localparam int PW = clog2_min1(NUM_SEQ);
    localparam int CW = $clog2(NUM_SEQ + 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    T mem_q [NUM_SEQ];

    // Decide push/pop acceptance and advance pointers and occupancy.
    always_comb begin
        do_pop    = pop && (count_q != '0);
        do_push   = push && ((count_q != CW'(NUM_SEQ)) || do_pop);
        drop      = push && !do_push;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(NUM_SEQ - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(NUM_SEQ - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        head      = mem_q[rd_ptr_q];
        not_empty = (count_q != '0);
        full      = (count_q == CW'(NUM_SEQ));
    end

    // Pointer and occupancy registers; active-low synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Array storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/rx_buffer.sv
// Receive-side array assembler: packs UART bytes LSB-first into elements,
// elements into an array, and queues completed arrays for downstream with a
// valid/ready handshake. data_end aborts a partially received array.
module rx_buffer
    import bitonic_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int NUM_SEQ = DEF_NUM_SEQ
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  byte_in,
    input  logic                        byte_valid,
    input  logic                        data_end,
    output logic [DEPTH-1:0][WIDTH-1:0] array_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic                        full,
    output logic                        overflow,
    output logic                        frame_err
);

    localparam int BPW = WIDTH / 8;
    localparam int BW  = clog2_min1(BPW);
    localparam int WW  = clog2_min1(DEPTH);

    typedef enum logic {IDLE, COLLECT} state_t;
    typedef logic [DEPTH-1:0][WIDTH-1:0] asm_t;

    state_t        state_q, state_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [WW-1:0] word_cnt_q, word_cnt_d;
    asm_t          asm_q, asm_d;
    logic          overflow_q, overflow_d;
    logic          frame_err_q, frame_err_d;
    logic          push;
    logic          pending;
    logic          fifo_drop;

    // Byte placement, counter advance, frame abort and FSM next state.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        asm_d       = asm_q;
        overflow_d  = overflow_q;
        frame_err_d = frame_err_q;
        push        = 1'b0;
        pending     = (state_q == COLLECT);
        if (byte_valid) begin
            asm_d[word_cnt_q][{byte_cnt_q, 3'b000} +: 8] = byte_in;
            if (byte_cnt_q == BW'(BPW - 1)) begin
                byte_cnt_d = '0;
                if (word_cnt_q == WW'(DEPTH - 1)) begin
                    word_cnt_d = '0;
                    push       = 1'b1;
                end else begin
                    word_cnt_d = word_cnt_q + WW'(1);
                end
            end else begin
                byte_cnt_d = byte_cnt_q + BW'(1);
            end
            pending = (byte_cnt_d != '0) || (word_cnt_d != '0);
        end
        // The byte of this cycle is already accounted for in pending.
        if (data_end && pending) begin
            byte_cnt_d  = '0;
            word_cnt_d  = '0;
            frame_err_d = 1'b1;
            pending     = 1'b0;
        end
        state_d = pending ? COLLECT : IDLE;
        if (fifo_drop) begin
            overflow_d = 1'b1;
        end
    end

    // Control state and sticky flags; active-low synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Assembly register; every position is rewritten before it is pushed.
    always_ff @(posedge clk) begin
        asm_q <= asm_d;
    end

    // The completing byte is merged via asm_d so the push carries the full array.
    array_fifo #(
        .NUM_SEQ (NUM_SEQ),
        .T       (asm_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (asm_d),
        .pop       (ready_in),
        .head      (array_out),
        .not_empty (valid_out),
        .full      (full),
        .drop      (fifo_drop)
    );

    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule
